// File: rtl/fc_layer_seq.sv
// Address sequencer and control for a fully-connected layer: bias preload, feature walk, weight-pair streaming.
// Optional bias preload phase is enabled by defining FC_BIAS_EN.
module fc_layer_seq #(
  parameter int N_IN      = 50,
  parameter int N_OUT     = 16,
  parameter int BIAS_BASE = 11,
  parameter int BIAS_AW   = 7,
  parameter int W_AW      = 10,
  parameter int FM_AW     = 6
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             start,
  output logic                                             busy,
  output logic                                             done,
  output logic                                             acc_clr,
  output logic                                             bias_bram_ena,
  output logic                                             bias_bram_enb,
  output logic [BIAS_AW-1:0]                               bias_bram_addra,
  output logic [BIAS_AW-1:0]                               bias_bram_addrb,
  output logic                                             bias_vld,
  output logic [$clog2(N_OUT/2 > 1 ? N_OUT/2 : 2)-1:0]     bias_pair,
  output logic                                             fm_bram_ena,
  output logic [FM_AW-1:0]                                 fm_bram_addra,
  output logic                                             fm_vld,
  output logic                                             w_bram_ena,
  output logic                                             w_bram_enb,
  output logic [W_AW-1:0]                                  w_bram_addra,
  output logic [W_AW-1:0]                                  w_bram_addrb,
  output logic                                             mac_vld,
  output logic [$clog2(N_OUT/2 > 1 ? N_OUT/2 : 2)-1:0]     mac_pair
);

  localparam int PW = $clog2(N_OUT/2 > 1 ? N_OUT/2 : 2);
  localparam logic [PW-1:0]    LAST_K = PW'(N_OUT/2 - 1);
  localparam logic [FM_AW-1:0] LAST_I = FM_AW'(N_IN - 1);

  if (N_OUT < 2 || (N_OUT % 2) != 0) begin : g_bad_nout
    $error("fc_layer_seq: N_OUT must be even and >= 2");
  end
  if (N_IN < 1) begin : g_bad_nin
    $error("fc_layer_seq: N_IN must be >= 1");
  end
  if ((64'd1 << W_AW) < 64'(N_IN * N_OUT)) begin : g_bad_waw
    $error("fc_layer_seq: W_AW too small for N_IN*N_OUT weights");
  end
  if ((64'd1 << FM_AW) < 64'(N_IN)) begin : g_bad_fmaw
    $error("fc_layer_seq: FM_AW too small for N_IN features");
  end
  if ((64'd1 << BIAS_AW) < 64'(BIAS_BASE + N_OUT)) begin : g_bad_baw
    $error("fc_layer_seq: BIAS_AW too small for BIAS_BASE+N_OUT");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FM,
    S_WT,
    S_DRAIN,
    S_DONE
`ifdef FC_BIAS_EN
    , S_BIAS
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [FM_AW-1:0]  i_q, i_d;
  logic [PW-1:0]     k_q, k_d;
  logic [W_AW-1:0]   w_q, w_d;
  logic              acc_clr_q, fm_vld_q, mac_vld_q;
  logic [PW-1:0]     mac_pair_q;
`ifdef FC_BIAS_EN
  logic [PW-1:0]     b_q, b_d;
  logic              bias_vld_q;
  logic [PW-1:0]     bias_pair_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      k_q     <= '0;
      w_q     <= '0;
`ifdef FC_BIAS_EN
      b_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      k_q     <= k_d;
      w_q     <= w_d;
`ifdef FC_BIAS_EN
      b_q     <= b_d;
`endif
    end
  end

  // w_q tracks i*N_OUT+2k incrementally, so no multiplier is needed.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    k_d     = k_q;
    w_d     = w_q;
`ifdef FC_BIAS_EN
    b_d     = b_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          i_d = '0;
          k_d = '0;
          w_d = '0;
`ifdef FC_BIAS_EN
          b_d     = '0;
          state_d = S_BIAS;
`else
          state_d = S_FM;
`endif
        end
      end
`ifdef FC_BIAS_EN
      S_BIAS: begin
        b_d = b_q + 1'b1;
        if (b_q == LAST_K) begin
          b_d     = '0;
          state_d = S_FM;
        end
      end
`endif
      S_FM: begin
        k_d     = '0;
        state_d = S_WT;
      end
      S_WT: begin
        k_d = k_q + 1'b1;
        w_d = w_q + W_AW'(2);
        if (k_q == LAST_K) begin
          k_d = '0;
          if (i_q == LAST_I) begin
            state_d = S_DRAIN;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = S_FM;
          end
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    done          = (state_q == S_DONE);
    fm_bram_ena   = (state_q == S_FM);
    fm_bram_addra = fm_bram_ena ? i_q : '0;
    w_bram_ena    = (state_q == S_WT);
    w_bram_enb    = w_bram_ena;
    w_bram_addra  = w_bram_ena ? w_q : '0;
    w_bram_addrb  = w_bram_ena ? (w_q | W_AW'(1)) : '0;
`ifdef FC_BIAS_EN
    bias_bram_ena   = (state_q == S_BIAS);
    bias_bram_enb   = bias_bram_ena;
    bias_bram_addra = bias_bram_ena ? BIAS_AW'(BIAS_BASE) + BIAS_AW'({b_q, 1'b0}) : '0;
    bias_bram_addrb = bias_bram_ena ? BIAS_AW'(BIAS_BASE + 1) + BIAS_AW'({b_q, 1'b0}) : '0;
`else
    bias_bram_ena   = 1'b0;
    bias_bram_enb   = 1'b0;
    bias_bram_addra = '0;
    bias_bram_addrb = '0;
`endif
  end

  // Valid strobes trail the read enables by the one-cycle BRAM latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_clr_q  <= 1'b0;
      fm_vld_q   <= 1'b0;
      mac_vld_q  <= 1'b0;
      mac_pair_q <= '0;
`ifdef FC_BIAS_EN
      bias_vld_q  <= 1'b0;
      bias_pair_q <= '0;
`endif
    end else begin
      acc_clr_q  <= (state_q == S_IDLE) && start;
      fm_vld_q   <= fm_bram_ena;
      mac_vld_q  <= w_bram_ena;
      mac_pair_q <= w_bram_ena ? k_q : '0;
`ifdef FC_BIAS_EN
      bias_vld_q  <= bias_bram_ena;
      bias_pair_q <= bias_bram_ena ? b_q : '0;
`endif
    end
  end

  assign acc_clr  = acc_clr_q;
  assign fm_vld   = fm_vld_q;
  assign mac_vld  = mac_vld_q;
  assign mac_pair = mac_pair_q;
`ifdef FC_BIAS_EN
  assign bias_vld  = bias_vld_q;
  assign bias_pair = bias_pair_q;
`else
  assign bias_vld  = 1'b0;
  assign bias_pair = '0;
`endif

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: default-size instance with a datapath/BRAM model and scoreboard, plus a 4x2 instance.
module tb_fc_layer_seq;

`ifdef FC_BIAS_EN
  localparam bit BIAS_ON = 1'b1;
`else
  localparam bit BIAS_ON = 1'b0;
`endif

  logic clk;
  logic s0, r0, s1, r1;
  int   n_checks = 0;
  int   n_errors = 0;

  logic       d0_busy, d0_done, d0_clr, d0_bena, d0_benb, d0_bvld, d0_fena, d0_fvld;
  logic       d0_wena, d0_wenb, d0_mvld;
  logic [6:0] d0_ba, d0_bb;
  logic [2:0] d0_bp, d0_mp;
  logic [5:0] d0_fa;
  logic [9:0] d0_wa, d0_wb;

  logic       d1_busy, d1_done, d1_clr, d1_bena, d1_benb, d1_bvld, d1_fena, d1_fvld;
  logic       d1_wena, d1_wenb, d1_mvld;
  logic [6:0] d1_ba, d1_bb;
  logic [0:0] d1_bp, d1_mp;
  logic [1:0] d1_fa;
  logic [2:0] d1_wa, d1_wb;

  fc_layer_seq #(.N_IN(50), .N_OUT(16), .BIAS_BASE(11), .BIAS_AW(7), .W_AW(10), .FM_AW(6)) dut0 (
    .clk(clk), .rst(r0), .start(s0), .busy(d0_busy), .done(d0_done), .acc_clr(d0_clr),
    .bias_bram_ena(d0_bena), .bias_bram_enb(d0_benb), .bias_bram_addra(d0_ba), .bias_bram_addrb(d0_bb),
    .bias_vld(d0_bvld), .bias_pair(d0_bp), .fm_bram_ena(d0_fena), .fm_bram_addra(d0_fa), .fm_vld(d0_fvld),
    .w_bram_ena(d0_wena), .w_bram_enb(d0_wenb), .w_bram_addra(d0_wa), .w_bram_addrb(d0_wb),
    .mac_vld(d0_mvld), .mac_pair(d0_mp)
  );

  fc_layer_seq #(.N_IN(4), .N_OUT(2), .BIAS_BASE(11), .BIAS_AW(7), .W_AW(3), .FM_AW(2)) dut1 (
    .clk(clk), .rst(r1), .start(s1), .busy(d1_busy), .done(d1_done), .acc_clr(d1_clr),
    .bias_bram_ena(d1_bena), .bias_bram_enb(d1_benb), .bias_bram_addra(d1_ba), .bias_bram_addrb(d1_bb),
    .bias_vld(d1_bvld), .bias_pair(d1_bp), .fm_bram_ena(d1_fena), .fm_bram_addra(d1_fa), .fm_vld(d1_fvld),
    .w_bram_ena(d1_wena), .w_bram_enb(d1_wenb), .w_bram_addra(d1_wa), .w_bram_addrb(d1_wb),
    .mac_vld(d1_mvld), .mac_pair(d1_mp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp_v);
    end
  endtask

  // BRAM contents and accumulator model for dut0.
  int bmem [128];
  int wmem [1024];
  int fmem [64];
  int acc  [16];
  int bda, bdb, fd, wda, wdb, feat;
  int exp_q [$];

  always @(negedge clk) begin
    if (d0_clr) for (int o = 0; o < 16; o++) acc[o] = 0;
    if (d0_bvld) begin
      acc[2*int'(d0_bp)]   = bda;
      acc[2*int'(d0_bp)+1] = bdb;
    end
    if (d0_mvld) begin
      acc[2*int'(d0_mp)]   += feat * wda;
      acc[2*int'(d0_mp)+1] += feat * wdb;
    end
    if (d0_fvld) feat = fd;
    if (d0_bena) bda = bmem[d0_ba];
    if (d0_benb) bdb = bmem[d0_bb];
    if (d0_fena) fd = fmem[d0_fa];
    if (d0_wena) wda = wmem[d0_wa];
    if (d0_wenb) wdb = wmem[d0_wb];
  end

  // Phase of cycle c counted from the cycle start is driven (0 idle,1 bias,2 fm,3 wt,4 drain,5 done).
  function automatic void phase(input int c, input int nin, input int nout, input int nb,
                                output int kind, output int idx, output int pair);
    int seg, base, drain, off;
    seg   = 1 + nout/2;
    base  = 1 + nb;
    drain = base + nin*seg;
    kind = 0; idx = 0; pair = 0;
    if (c >= 1 && c <= nb) begin
      kind = 1; pair = c - 1;
    end else if (c >= base && c < drain) begin
      off = c - base;
      idx = off / seg;
      if (off % seg == 0) kind = 2;
      else begin kind = 3; pair = off % seg - 1; end
    end else if (c == drain) kind = 4;
    else if (c == drain + 1) kind = 5;
  endfunction

  task automatic sample(input int sel, output logic [10:0] ctl, output int ba, output int bb,
                        output int bp, output int fa, output int wa, output int wb, output int mp);
    if (sel == 0) begin
      ctl = {d0_busy, d0_done, d0_clr, d0_bena, d0_benb, d0_bvld, d0_fena, d0_fvld, d0_wena, d0_wenb, d0_mvld};
      ba = int'(d0_ba); bb = int'(d0_bb); bp = int'(d0_bp); fa = int'(d0_fa);
      wa = int'(d0_wa); wb = int'(d0_wb); mp = int'(d0_mp);
    end else begin
      ctl = {d1_busy, d1_done, d1_clr, d1_bena, d1_benb, d1_bvld, d1_fena, d1_fvld, d1_wena, d1_wenb, d1_mvld};
      ba = int'(d1_ba); bb = int'(d1_bb); bp = int'(d1_bp); fa = int'(d1_fa);
      wa = int'(d1_wa); wb = int'(d1_wb); mp = int'(d1_mp);
    end
  endtask

  // Called one time unit after a rising edge; that cycle is cycle 0 (start high).
  task automatic run_layer(input int sel, input int rst_at, input bit repulse);
    int nin, nout, nb, donec, last, cur, idx, pair, prv, pidx, ppair;
    int ba, bb, bp, fa, wa, wb, mp, s;
    logic [10:0] ctl, ectl;
    logic st, rr;
    nin   = (sel == 0) ? 50 : 4;
    nout  = (sel == 0) ? 16 : 2;
    nb    = BIAS_ON ? nout/2 : 0;
    donec = 1 + nb + nin*(1 + nout/2) + 1;
    last  = (rst_at >= 0) ? rst_at + 3 : donec;
    if (sel == 0 && rst_at < 0) begin
      foreach (bmem[a]) bmem[a] = int'($urandom_range(0, 255)) - 128;
      foreach (wmem[a]) wmem[a] = int'($urandom_range(0, 255)) - 128;
      foreach (fmem[a]) fmem[a] = int'($urandom_range(0, 255)) - 128;
      for (int o = 0; o < 16; o++) begin
        s = BIAS_ON ? bmem[11 + o] : 0;
        for (int i = 0; i < 50; i++) s += fmem[i] * wmem[i*16 + o];
        exp_q.push_back(s);
      end
    end
    for (int c = 0; c <= last; c++) begin
      st = (c == 0) || (repulse && (c == 5 || c == 200 || c == donec));
      rr = (c == rst_at);
      if (sel == 0) begin s0 = st; r0 = rr; end
      else begin s1 = st; r1 = rr; end
      @(negedge clk);
      sample(sel, ctl, ba, bb, bp, fa, wa, wb, mp);
      if (rst_at >= 0 && c > rst_at) begin
        check("rst_ctl", ctl, 0);
        check("rst_addr", ba + bb + fa + wa + wb, 0);
        check("rst_pair", bp + mp, 0);
      end else begin
        phase(c, nin, nout, nb, cur, idx, pair);
        phase(c - 1, nin, nout, nb, prv, pidx, ppair);
        ectl = {cur >= 1 && cur <= 4, cur == 5, c == 1, cur == 1, cur == 1, prv == 1,
                cur == 2, prv == 2, cur == 3, cur == 3, prv == 3};
        check("ctl", ctl, ectl);
        if (nb == 0) check("bias_tied0", ba + bb + bp, 0);
        if (cur == 1) begin
          check("bias_addra", ba, 11 + 2*pair);
          check("bias_addrb", bb, 12 + 2*pair);
        end
        if (prv == 1) check("bias_pair", bp, ppair);
        if (cur == 2) check("fm_addr", fa, idx);
        if (cur == 3) begin
          check("w_addra", wa, idx*nout + 2*pair);
          check("w_addrb", wb, idx*nout + 2*pair + 1);
        end
        if (prv == 3) check("mac_pair", mp, ppair);
        if (sel == 0 && rst_at < 0 && c == donec) begin
          for (int o = 0; o < 16; o++) begin
            if (exp_q.size() == 0) check("sb_empty", 1, 0);
            else check($sformatf("acc%0d", o), acc[o], exp_q.pop_front());
          end
        end
      end
      @(posedge clk);
      #1;
    end
    if (sel == 0) begin s0 = 1'b0; r0 = 1'b0; end
    else begin s1 = 1'b0; r1 = 1'b0; end
  endtask

  initial begin
    logic [10:0] ctl;
    int ba, bb, bp, fa, wa, wb, mp;
    s0 = 1'b0; s1 = 1'b0; r0 = 1'b1; r1 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    r0 = 1'b0; r1 = 1'b0;
    @(negedge clk);
    for (int sel = 0; sel < 2; sel++) begin
      sample(sel, ctl, ba, bb, bp, fa, wa, wb, mp);
      check("reset_ctl", ctl, 0);
      check("reset_addr", ba + bb + fa + wa + wb, 0);
      check("reset_pair", bp + mp, 0);
    end
    @(posedge clk);
    #1;
    run_layer(1, -1, 1'b0);
    run_layer(0, -1, 1'b1);
    run_layer(0, -1, 1'b0);
    run_layer(0, 100, 1'b0);
    run_layer(0, -1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
# fc_layer_seq

Parametrised address sequencer and control for a LeNet fully-connected layer.
- Preloads output biases two at a time from the dual-port bias BRAM.
- Walks every input feature and streams the matching weight pairs from the dual-port weight BRAM.
- Emits aligned valid strobes to the MAC datapath, which accumulates N_OUT outputs.
- Sits between the layer scheduler (start/done) and the bias, weight and feature-map BRAMs; generalises the fixed 800-weight FC1 controller to any FC layer size.

## Interface
- N_IN, 50: input features per output.
- N_OUT, 16: output neurons. Must be even and ≥2; any other value is an elaboration error.
- BIAS_BASE, 11: bias BRAM address of output 0's bias.
- BIAS_AW, 7: bias address width.
- W_AW, 10: weight address width. Must satisfy 2^W_AW ≥ N_IN·N_OUT.
- FM_AW, 6: feature-map address width. Must satisfy 2^FM_AW ≥ N_IN.
- clk  in  1  clock, single domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- busy  out  1  high from the cycle after acceptance through DRAIN.
- done  out  1  one-cycle completion pulse.
- acc_clr  out  1  one-cycle pulse in the cycle after acceptance; the datapath clears its accumulators on it.
- bias_bram_ena / bias_bram_enb  out  1  bias read enables.
- bias_bram_addra / bias_bram_addrb  out  BIAS_AW  bias addresses (even / odd output of the pair).
- bias_vld  out  1  bias BRAM data valid; the datapath loads the pair into accumulators.
- bias_pair  out  clog2(N_OUT/2)  output-pair index for bias_vld.
- fm_bram_ena  out  1  feature read enable.
- fm_bram_addra  out  FM_AW  feature index.
- fm_vld  out  1  feature data valid; the datapath latches it.
- w_bram_ena / w_bram_enb  out  1  weight read enables.
- w_bram_addra / w_bram_addrb  out  W_AW  weight addresses.
- mac_vld  out  1  weight data valid; the datapath MACs the latched feature into the pair.
- mac_pair  out  clog2(N_OUT/2)  output-pair index for mac_vld.

## Operation
- Weight layout: weight(i,o) is at i·N_OUT+o. A read pair k of input i uses addra=i·N_OUT+2k and addrb=addra+1.
- IDLE: all enables low. start moves the FSM to BIAS and pulses acc_clr next cycle.
- BIAS: N_OUT/2 cycles. Pair k: addra=BIAS_BASE+2k, addrb=BIAS_BASE+2k+1, both enables high. Then → FM.
- FM: one cycle. fm_bram_ena=1, fm_bram_addra=i. Then → WT.
- WT: N_OUT/2 cycles. Both weight enables high, k stepping 0..N_OUT/2−1. After the last pair: → FM with i+1, or → DRAIN if i=N_IN−1.
- DRAIN: one cycle to cover the final mac_vld. Then → DONE.
- DONE: done=1 for one cycle, then → IDLE.
- Counters i and k are sized from the parameters and reset to 0 on acceptance. They never wrap mid-layer.
- start outside IDLE is ignored, including in the DONE cycle.
- rst at any point: FSM → IDLE and counters cleared. All outputs go to 0 next edge, including strobes, enables and addresses. No done is generated.

## Timing
- BRAM read latency is 1 cycle.
- bias_vld/bias_pair trail bias enable by 1 cycle. fm_vld trails fm_bram_ena by 1. mac_vld/mac_pair trail w_bram_ena by 1.
- fm_vld always coincides with the first WT cycle of its input, so the feature is latched before its first mac_vld.
- Enables and addresses are registered state outputs. No combinational path from start to any BRAM port.
- Cycle budget from start sampled (cycle 0): bias cycles 1..N_OUT/2, then N_IN·(1+N_OUT/2) FM/WT cycles, then DRAIN, then done.
- Defaults: done at cycle 460.

## Configuration
- FC_BIAS_EN defined: BIAS state present, behaviour as above.
- FC_BIAS_EN undefined: BIAS state and bias counter compiled out. IDLE → FM directly. Bias ports and bias_vld tied 0; accumulators start from acc_clr zero.
- Defaults without FC_BIAS_EN: done at cycle 452.

## Test plan
- Defaults, FC_BIAS_EN, start at cycle 0:
  - bias addra 11,13..25 and addrb 12..26 in cycles 1–8.
  - bias_vld in cycles 2–9.
  - fm_bram_addra=0 in cycle 9.
  - w addra 0..14 step 2 in cycles 10–17.
  - done only in cycle 460.
- Last input: fm_bram_addra=49 in cycle 450. Final weight pair addra=798, addrb=799 in cycle 458. Final mac_vld with mac_pair=7 in cycle 459.
- start re-pulsed in cycles 5, 200 and 460: ignored. Exactly one done. A new start in cycle 461 repeats the sequence.
- rst in cycle 100: every output 0 in cycle 101. No done. A fresh start gives the full 460-cycle sequence.
- N_IN=4, N_OUT=2, FC_BIAS_EN undefined:
  - bias ports stay 0.
  - weights 0/1, 2/3, 4/5, 6/7 on alternate cycles.
  - done at cycle 10.
- Scoreboard: a reference-model MAC over random BRAM contents matches all 16 accumulator results at done.
